// File: rtl/mult_div_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the shared 32-bit ALU for one add per cycle.
// Results accumulate in hi/lo; a divide by zero finishes immediately without a RUN phase.
module mult_div_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result
);

  localparam int unsigned W     = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_IDLE = 4'b0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_n;
  logic             op_q, op_n;
  logic [W-1:0]     opnd, opnd_n;    // mcand for MULTU, neg_d for DIVU
  logic [W-1:0]     d, d_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [W-1:0]     hi_n, lo_n;
  logic [W-1:0]     alu_a_n, alu_b_n;
  logic [3:0]       alu_ctrl_n;

  logic [W-1:0] rs;
  logic         t;
  logic         c;

  assign rs = {hi[W-2:0], lo[W-1]};
  assign t  = hi[W-1];
  assign c  = (alu_result < hi);

  // Next-state, datapath update and next ALU operand selection.
  always_comb begin
    state_n    = state;
    op_n       = op_q;
    opnd_n     = opnd;
    d_n        = d;
    cnt_n      = cnt;
    hi_n       = hi;
    lo_n       = lo;
    alu_a_n    = '0;
    alu_b_n    = '0;
    alu_ctrl_n = CTRL_IDLE;

    case (state)
      S_IDLE: begin
        if (start) begin
          op_n  = op;
          cnt_n = '0;
          hi_n  = '0;
          if (op) begin
            opnd_n = ~b_in + W'(1);
            d_n    = b_in;
            lo_n   = a_in;
            if (b_in == '0) begin
              state_n = S_DONE;
              hi_n    = a_in;
              lo_n    = '1;
            end else begin
              state_n = S_RUN;
            end
          end else begin
            opnd_n  = a_in;
            lo_n    = b_in;
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_n = cnt + CNT_W'(1);
        if (op_q) begin
          // Restoring step: subtract when the 33-bit partial remainder covers d.
          if (t || (rs >= d)) begin
            hi_n = alu_result;
            lo_n = {lo[W-2:0], 1'b1};
          end else begin
            hi_n = rs;
            lo_n = {lo[W-2:0], 1'b0};
          end
        end else if (lo[0]) begin
          hi_n = {c, alu_result[W-1:1]};
          lo_n = {alu_result[0], lo[W-1:1]};
        end else begin
          hi_n = {1'b0, hi[W-1:1]};
          lo_n = {hi[0], lo[W-1:1]};
        end
        if (cnt == CNT_W'(ITER - 1)) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Operands are registered so they line up with the hi/lo values of the coming RUN cycle.
    if (state_n == S_RUN) begin
      alu_ctrl_n = CTRL_ADD;
      alu_b_n    = opnd_n;
      alu_a_n    = op_n ? {hi_n[W-2:0], lo_n[W-1]} : hi_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= 1'b0;
      opnd     <= '0;
      d        <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= CTRL_IDLE;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      opnd     <= opnd_n;
      d        <= d_n;
      cnt      <= cnt_n;
      hi       <= hi_n;
      lo       <= lo_n;
      busy     <= (state_n != S_IDLE);
      done     <= (state_n == S_DONE);
      alu_a    <= alu_a_n;
      alu_b    <= alu_b_n;
      alu_ctrl <= alu_ctrl_n;
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: directed vector table, start/reset corner sequences,
// and back-to-back random operations checked against plain 64-bit arithmetic.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  // Main ALU stand-in: add or AND.
  assign alu_result = (alu_ctrl == 4'b0010) ? (alu_a + alu_b) : (alu_a & alu_b);

  always #5 clk = ~clk;

  mult_div_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the specified results straight from integer arithmetic.
  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rhi, output logic [31:0] rlo, output int rlat);
    logic [63:0] p;
    if (!o) begin
      p    = 64'(a) * 64'(b);
      rhi  = p[63:32];
      rlo  = p[31:0];
      rlat = 33;
    end else if (b == 32'd0) begin
      rhi  = a;
      rlo  = 32'hFFFF_FFFF;
      rlat = 1;
    end else begin
      rhi  = a % b;
      rlo  = a / b;
      rlat = 33;
    end
  endtask

  // Holds start until accepted, then counts cycles to done and audits the ALU drive.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input int pulse_cyc,
                       output logic [31:0] rhi, output logic [31:0] rlo,
                       output int lat, output int wait_edges, output int ctrl_bad);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    wait_edges = 0;
    do begin
      step();
      wait_edges++;
    end while (!busy && wait_edges < 5);
    start    = 1'b0;
    op       = ~o;
    a_in     = $urandom;
    b_in     = $urandom;
    lat      = -1;
    ctrl_bad = 0;
    rhi      = hi;
    rlo      = lo;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        rhi = hi;
        rlo = lo;
        if (alu_ctrl != 4'b0000 || alu_a != 32'd0 || alu_b != 32'd0) ctrl_bad++;
        break;
      end
      if (alu_ctrl != 4'b0010) ctrl_bad++;
      if (k == pulse_cyc) begin
        start = 1'b1;
        op    = $urandom_range(1, 0);
      end
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] rhi, rlo, ehi, elo;
    int          lat, we, cb, elat;
    logic        o;
    logic [31:0] a, b;

    vecs.push_back('{1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         33});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  33});
    vecs.push_back('{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         33});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  33});
    vecs.push_back('{1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1});
    vecs.push_back('{1'b0, 32'h8000_0000,  32'd2,          32'd1,          32'd0,          33});
    vecs.push_back('{1'b1, 32'd3,          32'd10,         32'd3,          32'd0,          33});
    vecs.push_back('{1'b1, 32'h8000_0001,  32'h8000_0000,  32'd1,          32'd1,          33});

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a_in  = 32'd0;
    b_in  = 32'd0;
    repeat (3) step();
    chk("reset_state", {busy, done, hi, lo}, {1'b0, 1'b0, 32'd0, 32'd0});
    chk("reset_alu", {alu_ctrl, alu_a, alu_b}, {4'b0000, 32'd0, 32'd0});
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, rhi, rlo, lat, we, cb);
      chk($sformatf("vec%0d_accept", i), 64'(we), 64'd1);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_hi", i), 64'(rhi), 64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_lo", i), 64'(rlo), 64'(vecs[i].exp_lo));
      chk($sformatf("vec%0d_alu_drive", i), 64'(cb), 64'd0);
      step();
      chk($sformatf("vec%0d_after_done", i), {busy, done}, 2'b00);
      chk($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // Stray start in the middle of a MULTU must not disturb it.
    do_op(1'b0, 32'd7, 32'd6, 10, rhi, rlo, lat, we, cb);
    chk("pulse_latency", 64'(lat), 64'd33);
    chk("pulse_result", {rhi, rlo}, {32'd0, 32'd42});
    step();

    // Reset mid-RUN discards the operation.
    start = 1'b1; op = 1'b0; a_in = 32'd7; b_in = 32'd6;
    step();
    start = 1'b0;
    repeat (11) step();
    chk("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun_reset_state", {busy, done, hi, lo}, {1'b0, 1'b0, 32'd0, 32'd0});
    chk("midrun_reset_alu", {alu_ctrl, alu_a, alu_b}, {4'b0000, 32'd0, 32'd0});
    cb = 0;
    repeat (40) begin
      if (done || busy) cb++;
      step();
    end
    chk("midrun_no_done", 64'(cb), 64'd0);

    // Reset in the DONE cycle clears hi/lo.
    do_op(1'b0, 32'd9, 32'd9, 0, rhi, rlo, lat, we, cb);
    chk("donecyc_result", {rhi, rlo}, {32'd0, 32'd81});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("donecyc_reset", {busy, done, hi, lo}, {1'b0, 1'b0, 32'd0, 32'd0});
    step();

    // Random back-to-back: each start is raised in the previous done cycle.
    for (int n = 0; n < 1000; n++) begin
      o = 1'($urandom_range(1, 0));
      a = $urandom;
      case ($urandom_range(7, 0))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(15, 1));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model(o, a, b, ehi, elo, elat);
      do_op(o, a, b, 0, rhi, rlo, lat, we, cb);
      if (n > 0) chk($sformatf("rnd%0d_accept", n), 64'(we), 64'd2);
      chk($sformatf("rnd%0d_op%0d_a%h_b%h", n, o, a, b),
          {rhi, rlo}, {ehi, elo});
      chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(elat));
      if (cb != 0) chk($sformatf("rnd%0d_alu_drive", n), 64'(cb), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
